// File: rtl/tcm_pkg.sv
// Shared types and size helpers for the three-way Toom-Cook style GF(2) multiplier.
package tcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int limb_width(input int n);
    return ceil_div(n, 3);
  endfunction

  function automatic int iter_count(input int n, input int digit);
    return ceil_div(limb_width(n), digit);
  endfunction

endpackage

// File: rtl/clmul_digit_engine.sv
// K x K digit-serial carry-less multiply-accumulate: each enabled cycle folds
// DIGIT bits of x (digit idx) into the accumulator as shifted copies of y.
module clmul_digit_engine
  import tcm_pkg::*;
#(
  parameter int K     = 78,
  parameter int DIGIT = 1,
  parameter int ITER  = 78,
  parameter int IW    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [IW-1:0]   idx,
  input  logic [K-1:0]    x,
  input  logic [K-1:0]    y,
  output logic [2*K-2:0]  acc
);

  localparam int XW = ITER * DIGIT;
  localparam int PW = 2 * K - 1;

  logic [XW-1:0]    x_pad;
  logic [DIGIT-1:0] dig;
  logic [PW-1:0]    y_ext;
  logic [PW-1:0]    part;
  logic [PW-1:0]    acc_q, acc_d;

  // x is zero-padded up to ITER*DIGIT bits so the last digit reads zeros past K.
  assign x_pad = XW'(x);
  assign dig   = DIGIT'(x_pad >> (int'(idx) * DIGIT));
  assign y_ext = PW'(y);

  always_comb begin
    part = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (dig[j]) part = part ^ (y_ext << (int'(idx) * DIGIT + j));
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q ^ part;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/three_way_toom_cook_ds.sv
// GF(2) carry-less multiplier: 3-way limb split, nine digit-serial engines, fold + recombine.
// Optional early finish when the rest of a is zero: THREE_WAY_TOOM_COOK_ZERO_SKIP_EN.
module three_way_toom_cook_ds
  import tcm_pkg::*;
#(
  parameter int N     = 233,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   c,
  output logic [1:0]       dbg_state
);

  localparam int K    = limb_width(N);
  localparam int ITER = iter_count(N, DIGIT);
  localparam int IW   = $clog2(ITER + 1);
  localparam int PW   = 2 * K - 1;
  localparam int FW   = 6 * K;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_FIN  = FIN;

  // Handshake: start is honoured only in IDLE and not in the cycle done is high;
  // done pulses for one cycle exactly when c takes a new value.
  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2*N-1:0] c_q, c_d;
  logic           done_q, done_d;
  logic           clr, en, last_digit, rest_zero;

  logic [3*K-1:0] a_pad, b_pad;
  logic [K-1:0]   al [3];
  logic [K-1:0]   bl [3];
  logic [K-1:0]   a_or;
  logic [PW-1:0]  prod [3][3];
  logic [PW-1:0]  coef [5];
  logic [FW-1:0]  c_wide;
  logic [2*N-1:0] c_full;

  assign a_pad = (3 * K)'(a_q);
  assign b_pad = (3 * K)'(b_q);

  always_comb begin
    for (int l = 0; l < 3; l++) begin
      al[l] = a_pad[l*K +: K];
      bl[l] = b_pad[l*K +: K];
    end
  end

  assign a_or = al[0] | al[1] | al[2];

  for (genvar i = 0; i < 3; i++) begin : g_x
    for (genvar j = 0; j < 3; j++) begin : g_y
      clmul_digit_engine #(
        .K(K), .DIGIT(DIGIT), .ITER(ITER), .IW(IW)
      ) u_eng (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .idx(idx_q),
        .x(al[i]), .y(bl[j]), .acc(prod[i][j])
      );
    end
  end

  // Products with equal limb-index sum land on the same K-aligned coefficient.
  always_comb begin
    for (int s = 0; s < 5; s++) coef[s] = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) coef[i+j] = coef[i+j] ^ prod[i][j];
    end
    c_wide = '0;
    for (int s = 0; s < 5; s++) c_wide = c_wide ^ (FW'(coef[s]) << (s * K));
  end

  assign c_full     = (2 * N)'(c_wide);
  assign last_digit = (idx_q == IW'(ITER - 1));

`ifdef THREE_WAY_TOOM_COOK_ZERO_SKIP_EN
  assign rest_zero = ~|(a_or >> (int'(idx_q) * DIGIT));
`else
  assign rest_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          clr     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        en    = 1'b1;
        idx_d = idx_q + IW'(1);
        if (last_digit || rest_zero) state_d = ST_FIN;
      end
      ST_FIN: begin
        c_d     = c_full;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_FIN);
  assign done      = done_q;
  assign c         = c_q;
  assign dbg_state = state_q;

  // a_or is only consumed by the zero-skip path; keep it referenced in both builds.
  logic unused_ok;
  assign unused_ok = ^a_or;

endmodule

// File: tb/tb_three_way_toom_cook_ds.sv
// Self-checking bench for three_way_toom_cook_ds against a bitwise carry-less reference.
module tb_three_way_toom_cook_ds;

  parameter int N     = 233;
  parameter int DIGIT = 1;

  localparam int CW   = 2 * N;
  localparam int K    = (N + 2) / 3;
  localparam int ITER = (K + DIGIT - 1) / DIGIT;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          busy;
  logic          done;
  logic [CW-1:0] c;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];

  three_way_toom_cook_ds #(.N(N), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [CW-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [CW-1:0] r;
    logic [CW-1:0] ye;
    r  = '0;
    ye = CW'(y);
    for (int i = 0; i < N; i++) if (x[i]) r = r ^ (ye << i);
    return r;
  endfunction

  // First digit position from which every limb of x holds only zeros.
  function automatic int exp_latency(input logic [N-1:0] x);
    logic [3*K-1:0] xp;
    int first_zero;
    xp = (3 * K)'(x);
    first_zero = ITER;
    for (int t = ITER - 1; t >= 0; t--) begin
      bit any;
      any = 1'b0;
      for (int l = 0; l < 3; l++)
        for (int p = t * DIGIT; p < K; p++) if (xp[l*K + p]) any = 1'b1;
      if (!any) first_zero = t;
    end
`ifdef THREE_WAY_TOOM_COOK_ZERO_SKIP_EN
    if (first_zero < ITER) return first_zero + 2;
`endif
    return ITER + 1 + 0 * first_zero;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(clmul(av, bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; optional start pulses with fresh operands at cycles p1/p2.
  task automatic wait_done(input int p1, input int p2, output int lat, output int bcnt);
    int cyc;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 400) begin
      if (cyc == p1 || cyc == p2) begin
        start = 1'b1;
        a = rand_vec();
        b = rand_vec();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    lat = done ? cyc : -1;
  endtask

  task automatic finish_op(input string tag, input logic [N-1:0] av, input int p1, input int p2);
    int lat, bc;
    logic [CW-1:0] e;
    wait_done(p1, p2, lat, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_latency"}, CW'(lat), CW'(exp_latency(av)));
    check({tag, "_product"}, c, e);
    check({tag, "_busy_cycles"}, CW'(bc), CW'(exp_latency(av)));
    a = rand_vec();
    b = rand_vec();
    @(negedge clk);
    check({tag, "_done_pulse"}, CW'(done), CW'(0));
    repeat (3) @(negedge clk);
    check({tag, "_held"}, c, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] av, bv, ones, top;
    logic [CW-1:0] e;
    int lat, bc, w, seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", CW'(busy), CW'(0));
    check("reset_done", CW'(done), CW'(0));
    check("reset_c", c, CW'(0));
    rst = 1'b0;

    // Directed operands
    ones = '1;
    top  = '0;
    top[N-1] = 1'b1;
    issue(N'(1), N'(1));     finish_op("one_x_one", N'(1), -1, -1);
    check("one_x_one_val", c, CW'(1));
    issue(top, top);         finish_op("top_x_top", top, -1, -1);
    e = '0; e[2*N-2] = 1'b1;
    check("top_x_top_val", c, e);
    issue(N'(3), N'(3));     finish_op("three_x_three", N'(3), -1, -1);
    check("three_x_three_val", c, CW'(5));
    issue(ones, N'(1));      finish_op("ones_x_one", ones, -1, -1);
    check("ones_x_one_val", c, CW'(ones));
    issue(N'(0), rand_vec()); finish_op("zero_a", N'(0), -1, -1);
    bv = rand_vec();
    issue(top, bv);          finish_op("top_x_rand", top, -1, -1);
    check("top_x_rand_val", c, CW'(bv) << (N - 1));

    // Start pulses while busy must be ignored
    av = rand_vec(); bv = rand_vec();
    issue(av, bv);           finish_op("busy_start", av, 10, 40);

    // start coinciding with done is not accepted
    av = rand_vec(); bv = rand_vec();
    issue(av, bv);
    wait_done(-1, -1, lat, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("at_done_product", c, e);
    start = 1'b1; a = rand_vec(); b = rand_vec();
    @(negedge clk);
    start = 1'b0;
    check("at_done_not_accepted", CW'(busy), CW'(0));

    // Reset in the middle of a run
    av = rand_vec(); bv = rand_vec();
    issue(av, bv);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("midrst_busy", CW'(busy), CW'(0));
    check("midrst_done", CW'(done), CW'(0));
    check("midrst_c", c, CW'(0));
    seen = 0;
    repeat (ITER + 10) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrst_no_result", CW'(seen), CW'(0));
    issue(N'(5), N'(7));     finish_op("five_x_seven", N'(5), -1, -1);
    check("five_x_seven_val", c, CW'(27));

    // Random dense and sparse operands
    for (int i = 0; i < 30; i++) begin
      av = rand_vec();
      bv = rand_vec();
      if (i % 2 == 1) begin
        w  = $urandom_range(1, N);
        av = av & (ones >> (N - w));
      end
      if (i % 7 == 3) av = '0;
      issue(av, bv);
      finish_op("random", av, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
